// File: rtl/pll_reconfig_sequencer.sv
// Streams a stored PLL frequency profile to the reconfig IP over Avalon-MM, issues START,
// then waits for a synchronised lock with a blanking window, timeout and bounded retries.
module pll_reconfig_sequencer #(
  parameter int NUM_CLOCKS   = 4,
  parameter int PROFILES     = 4,
  parameter int LOCK_BLANK   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  localparam int PW          = $clog2(PROFILES)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          tbl_wr,
  input  logic [PW-1:0] tbl_prof,
  input  logic [4:0]    tbl_field,
  input  logic [31:0]   tbl_data,
  input  logic          req,
  input  logic [PW-1:0] req_prof,
  input  logic          pll_locked,
  input  logic          mgmt_waitrequest,
  output logic [5:0]    mgmt_address,
  output logic          mgmt_write,
  output logic [31:0]   mgmt_writedata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [PW-1:0] cur_prof,
  output logic          tbl_rej
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > LOCK_BLANK) ? LOCK_TIMEOUT : LOCK_BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [PW:0] PROF_LIM = (PW+1)'(PROFILES);

  typedef enum logic [3:0] {IDLE, MODE, WR_N, WR_M, WR_K, WR_C, START, BLANK, LOCKW} state_e;

  state_e         state_q;
  logic [5:0]     addr_q;
  logic           wr_q;
  logic [31:0]    data_q;
  logic           busy_q, done_q, error_q, tbl_rej_q;
  logic [1:0]     err_code_q;
  logic [PW-1:0]  cur_prof_q, prof_q;
  logic [4:0]     idx_q;
  logic [CW-1:0]  cnt_q;
  logic [RW-1:0]  retry_q;
  logic           lk_meta_q, lk_s_q;

  logic [17:0]    n_q [PROFILES];
  logic [17:0]    m_q [PROFILES];
  logic [31:0]    k_q [PROFILES];
  logic [17:0]    c_q [PROFILES][NUM_CLOCKS];

  logic [17:0]    rd_n, rd_m, rd_c;
  logic [31:0]    rd_k;
  logic [4:0]     c_idx;
  logic           wr_done, req_bad, tbl_bad;

  assign wr_done = wr_q & ~mgmt_waitrequest;
  assign req_bad = ({1'b0, req_prof} >= PROF_LIM);
  assign tbl_bad = ({1'b0, tbl_prof} >= PROF_LIM) || (tbl_field >= 5'(NUM_CLOCKS + 3));

  // Table is read live, so a write landing on the accept edge is seen by the N write onwards
  always_comb begin
    c_idx = (state_q == WR_C) ? idx_q + 5'd1 : '0;
    rd_n  = '0;
    rd_m  = '0;
    rd_k  = '0;
    rd_c  = '0;
    for (int unsigned i = 0; i < PROFILES; i++) begin
      if (prof_q == PW'(i)) begin
        rd_n = n_q[i];
        rd_m = m_q[i];
        rd_k = k_q[i];
        for (int unsigned j = 0; j < NUM_CLOCKS; j++)
          if (c_idx == 5'(j)) rd_c = c_q[i][j];
      end
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      tbl_rej_q <= 1'b0;
      for (int unsigned i = 0; i < PROFILES; i++) begin
        n_q[i] <= '0;
        m_q[i] <= '0;
        k_q[i] <= '0;
        for (int unsigned j = 0; j < NUM_CLOCKS; j++) c_q[i][j] <= '0;
      end
    end else begin
      tbl_rej_q <= 1'b0;
      if (tbl_wr) begin
        if (state_q != IDLE || tbl_bad) begin
          tbl_rej_q <= 1'b1;
        end else begin
          for (int unsigned i = 0; i < PROFILES; i++) begin
            if (tbl_prof == PW'(i)) begin
              case (tbl_field)
                5'd0:    n_q[i] <= tbl_data[17:0];
                5'd1:    m_q[i] <= tbl_data[17:0];
                5'd2:    k_q[i] <= tbl_data;
                default: for (int unsigned j = 0; j < NUM_CLOCKS; j++)
                           if (tbl_field == 5'(j + 3)) c_q[i][j] <= tbl_data[17:0];
              endcase
            end
          end
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
      cur_prof_q <= '0;
      prof_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          if (req_bad) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd1;
          end else begin
            state_q    <= MODE;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            err_code_q <= '0;
            prof_q     <= req_prof;
            retry_q    <= '0;
            wr_q       <= 1'b1;
            addr_q     <= 6'h00;
            data_q     <= '0;
          end
        end
        MODE: if (wr_done) begin
          state_q <= WR_N;
          addr_q  <= 6'h03;
          data_q  <= {14'b0, rd_n};
        end
        WR_N: if (wr_done) begin
          state_q <= WR_M;
          addr_q  <= 6'h04;
          data_q  <= {14'b0, rd_m};
        end
        WR_M: if (wr_done) begin
          state_q <= WR_K;
          addr_q  <= 6'h07;
          data_q  <= rd_k;
        end
        WR_K, WR_C: if (wr_done) begin
          if (state_q == WR_C && idx_q == 5'(NUM_CLOCKS - 1)) begin
            state_q <= START;
            addr_q  <= 6'h02;
            data_q  <= 32'd1;
          end else begin
            state_q <= WR_C;
            idx_q   <= c_idx;
            addr_q  <= 6'h05;
            data_q  <= {9'b0, c_idx, rd_c};
          end
        end
        START: if (wr_done) begin
          state_q <= BLANK;
          wr_q    <= 1'b0;
          cnt_q   <= '0;
        end
        BLANK: begin
          if (cnt_q == CW'(LOCK_BLANK - 1)) begin
            state_q <= LOCKW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOCKW: begin
          // Lock is tested first so it wins over a coincident timeout
          if (lk_s_q) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            cur_prof_q <= prof_q;
          end else if (cnt_q >= CW'(LOCK_TIMEOUT - 1)) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              state_q <= START;
              retry_q <= retry_q + RW'(1);
              wr_q    <= 1'b1;
              addr_q  <= 6'h02;
              data_q  <= 32'd1;
            end else begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
              err_code_q <= 2'd2;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mgmt_address   = addr_q;
  assign mgmt_write     = wr_q;
  assign mgmt_writedata = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign cur_prof       = cur_prof_q;
  assign tbl_rej        = tbl_rej_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Randomised bench for pll_reconfig_sequencer against a table/queue model of the write stream,
// lock blanking, timeout/retry timing, table rejection and reset behaviour.
module tb_pll_reconfig_sequencer;

  localparam int NC = 4;
  localparam int PR = 5;
  localparam int LB = 16;
  localparam int LT = 200;
  localparam int MR = 3;
  localparam int PW = $clog2(PR);

  logic          refclk = 1'b0;
  logic          rst = 1'b0;
  logic          tbl_wr = 1'b0;
  logic [PW-1:0] tbl_prof = '0;
  logic [4:0]    tbl_field = '0;
  logic [31:0]   tbl_data = '0;
  logic          req = 1'b0;
  logic [PW-1:0] req_prof = '0;
  logic          pll_locked = 1'b0;
  logic          mgmt_waitrequest = 1'b0;
  logic [5:0]    mgmt_address;
  logic          mgmt_write;
  logic [31:0]   mgmt_writedata;
  logic          busy, done, error, tbl_rej;
  logic [1:0]    err_code;
  logic [PW-1:0] cur_prof;

  pll_reconfig_sequencer #(
    .NUM_CLOCKS(NC), .PROFILES(PR), .LOCK_BLANK(LB), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .tbl_wr(tbl_wr), .tbl_prof(tbl_prof), .tbl_field(tbl_field),
    .tbl_data(tbl_data), .req(req), .req_prof(req_prof), .pll_locked(pll_locked),
    .mgmt_waitrequest(mgmt_waitrequest), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .cur_prof(cur_prof), .tbl_rej(tbl_rej)
  );

  always #5 refclk = ~refclk;

  int errs = 0;
  int checks = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  logic stall_en = 1'b0;
  logic hold_wait = 1'b0;
  int   consec = 0;
  always @(posedge refclk) begin
    #1;
    if (hold_wait) begin
      mgmt_waitrequest <= 1'b1;
    end else if (stall_en && consec < 5 && $urandom_range(0, 1) == 1) begin
      mgmt_waitrequest <= 1'b1;
      consec <= consec + 1;
    end else begin
      mgmt_waitrequest <= 1'b0;
      consec <= 0;
    end
  end

  logic [37:0] got_q[$];
  int          start_cnt = 0;
  int          last_start_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_aw = '0;

  always @(negedge refclk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        chk_eq("stall_hold", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'({1'b1, prev_aw}));
      if (mgmt_write && !mgmt_waitrequest) begin
        got_q.push_back({mgmt_address, mgmt_writedata});
        if (mgmt_address == 6'h02) begin
          start_cnt++;
          last_start_cyc = cyc;
        end
      end
      prev_stall <= mgmt_write && mgmt_waitrequest;
      prev_aw    <= {mgmt_address, mgmt_writedata};
    end
  end

  logic [17:0]   mn[PR], mm[PR];
  logic [31:0]   mk[PR];
  logic [17:0]   mc[PR][NC];
  logic [PW-1:0] m_cur = '0;
  logic [37:0]   exp_q[$];

  task automatic tick();
    @(negedge refclk);
    #1;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PR; i++) begin
      mn[i] = '0; mm[i] = '0; mk[i] = '0;
      for (int j = 0; j < NC; j++) mc[i][j] = '0;
    end
    m_cur = '0;
  endtask

  task automatic model_store(input int p, input int f, input logic [31:0] d);
    case (f)
      0: mn[p] = d[17:0];
      1: mm[p] = d[17:0];
      2: mk[p] = d;
      default: mc[p][f-3] = d[17:0];
    endcase
  endtask

  task automatic tbl_write(input int p, input int f, input logic [31:0] d, input bit quiet);
    bit rej;
    rej = (p >= PR) || (f >= NC + 3);
    tbl_wr = 1'b1; tbl_prof = PW'(p); tbl_field = 5'(f); tbl_data = d;
    tick();
    tbl_wr = 1'b0;
    if (!quiet || rej) chk_eq("tbl_rej", 64'(tbl_rej), 64'(rej));
    if (!rej) model_store(p, f, d);
  endtask

  task automatic build_exp(input int p, input int starts);
    exp_q.delete();
    exp_q.push_back({6'h00, 32'h0});
    exp_q.push_back({6'h03, 14'b0, mn[p]});
    exp_q.push_back({6'h04, 14'b0, mm[p]});
    exp_q.push_back({6'h07, mk[p]});
    for (int j = 0; j < NC; j++) exp_q.push_back({6'h05, 9'b0, 5'(j), mc[p][j]});
    for (int s = 0; s < starts; s++) exp_q.push_back({6'h02, 32'h1});
  endtask

  // lock_dly < 0: never lock. poke: table write + second req while busy. same_wr: table write with req.
  task automatic do_seq(input int p, input int lock_dly, input bit poke, input bit same_wr);
    bit fin;
    int t_end;
    int starts_exp;
    got_q.delete();
    start_cnt = 0;
    pll_locked = 1'b0;
    req = 1'b1; req_prof = PW'(p);
    if (same_wr) begin
      tbl_wr = 1'b1; tbl_prof = PW'(p); tbl_field = 5'd0; tbl_data = $urandom;
      model_store(p, 0, tbl_data);
    end
    tick();
    req = 1'b0; tbl_wr = 1'b0;
    if (same_wr) chk_eq("same_wr_rej", 64'(tbl_rej), 64'(0));
    chk_eq("busy_on_req", 64'(busy), 64'(1));
    chk_eq("err_clr", 64'({error, err_code}), 64'(0));
    chk_eq("first_wr", 64'({mgmt_write, mgmt_address}), 64'({1'b1, 6'h00}));
    fin = 1'b0;
    t_end = 0;
    for (int k = 0; k < 5000 && !fin; k++) begin
      tick();
      if (poke && k == 3) begin
        tbl_wr = 1'b1; tbl_prof = PW'(p); tbl_field = 5'd6; tbl_data = {14'b0, ~mc[p][3]};
        req = 1'b1; req_prof = PW'((p + 1) % PR);
      end
      if (poke && k == 4) begin
        chk_eq("busy_tbl_rej", 64'(tbl_rej), 64'(1));
        tbl_wr = 1'b0; req = 1'b0;
      end
      if (lock_dly >= 0 && start_cnt > 0 && !pll_locked && cyc - last_start_cyc >= lock_dly)
        pll_locked = 1'b1;
      if (done || error) begin
        fin = 1'b1;
        t_end = cyc;
      end
    end
    chk_eq("seq_finished", 64'(fin), 64'(1));
    if (lock_dly >= 0) begin
      starts_exp = 1;
      chk_eq("done", 64'({done, error}), 64'({1'b1, 1'b0}));
      chk_eq("lock_lat", 64'(t_end - last_start_cyc), 64'(imax(lock_dly + 3, LB + 2)));
      chk_eq("cur_prof", 64'(cur_prof), 64'(p));
      m_cur = PW'(p);
    end else begin
      starts_exp = MR + 1;
      chk_eq("err_timeout", 64'({error, err_code}), 64'({1'b1, 2'd2}));
      chk_eq("timeout_lat", 64'(t_end - last_start_cyc), 64'(LB + LT + 1));
      chk_eq("cur_prof_kept", 64'(cur_prof), 64'(m_cur));
    end
    chk_eq("busy_end", 64'(busy), 64'(0));
    chk_eq("start_cnt", 64'(start_cnt), 64'(starts_exp));
    tick();
    chk_eq("done_pulse", 64'(done), 64'(0));
    build_exp(p, starts_exp);
    chk_eq("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk_eq($sformatf("wr%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    pll_locked = 1'b0;
    repeat (3) tick();
  endtask

  task automatic bad_req(input int p);
    got_q.delete();
    req = 1'b1; req_prof = PW'(p);
    tick();
    req = 1'b0;
    chk_eq("bad_err", 64'({error, err_code, busy}), 64'({1'b1, 2'd1, 1'b0}));
    repeat (4) tick();
    chk_eq("bad_nowr", 64'(got_q.size()), 64'(0));
    chk_eq("bad_cur", 64'(cur_prof), 64'(m_cur));
  endtask

  task automatic reset_mid(input int p);
    bit seen;
    stall_en = 1'b0;
    req = 1'b1; req_prof = PW'(p);
    tick();
    req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (mgmt_write && mgmt_address == 6'h05) seen = 1'b1;
    end
    chk_eq("reach_wrc", 64'(seen), 64'(1));
    hold_wait = 1'b1;
    tick();
    tick();
    chk_eq("wrc_stall", 64'({mgmt_write, mgmt_waitrequest, mgmt_address}), 64'({2'b11, 6'h05}));
    #2 rst = 1'b0;
    #1;
    chk_eq("rst_async", 64'({mgmt_write, busy}), 64'(0));
    hold_wait = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    repeat (4) tick();
    chk_eq("no_resume", 64'({mgmt_write, busy, done, error, err_code, cur_prof, tbl_rej}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    chk_eq("reset_out", 64'({mgmt_address, mgmt_write, mgmt_writedata, busy, done, error,
                             err_code, cur_prof, tbl_rej}), 64'(0));
    rst = 1'b1;
    tick();
    chk_eq("idle_out", 64'({mgmt_write, busy, done, error}), 64'(0));

    for (int p = 0; p < PR; p++)
      for (int f = 0; f < NC + 3; f++) tbl_write(p, f, $urandom, 1'b1);
    tbl_write(1, 0, 32'h0001_0000, 1'b0);
    tbl_write(1, 1, 32'h0000_0404, 1'b0);
    tbl_write(1, 2, 32'h8000_0000, 1'b0);
    for (int f = 3; f < NC + 3; f++) tbl_write(1, f, 32'h0000_0202, 1'b0);

    do_seq(1, 20, 1'b0, 1'b0);
    stall_en = 1'b1;
    do_seq(1, 20, 1'b0, 1'b0);
    stall_en = 1'b0;
    do_seq(2, -1, 1'b0, 1'b0);
    bad_req(5);
    bad_req(7);
    tbl_write(0, 9, $urandom, 1'b0);
    tbl_write(6, 0, $urandom, 1'b0);
    do_seq(1, 10, 1'b1, 1'b0);
    do_seq(3, 25, 1'b0, 1'b1);
    do_seq(0, 0, 1'b0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 8; w++)
        tbl_write($urandom_range(0, 5), $urandom_range(0, 7), $urandom, 1'b0);
      stall_en = 1'($urandom_range(0, 1));
      do_seq($urandom_range(0, PR - 1), $urandom_range(0, 40), 1'b0, 1'b0);
    end
    stall_en = 1'b0;

    reset_mid(4);
    for (int f = 0; f < NC + 3; f++) tbl_write(4, f, $urandom, 1'b0);
    do_seq(4, 5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
